// File: rtl/sobel_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_stream_ctrl
//  Purpose  : Sequences a stall-able Sobel convolution datapath between an
//             AXI-Stream input and an AXI-Stream output. Generates the
//             datapath stall and per-frame datapath reset, tracks valid beats
//             through the datapath with a tag pipeline, flushes the pipeline
//             at end of frame and buffers results in a 2-entry output FIFO.
//             Output tlast/tuser are regenerated from internal counters.
//  Ports    : clk, aresetn (sync, active-low)
//             start / busy / frame_done / err_sync  - control and status
//             s_t*                                   - AXI-Stream input
//             m_t*                                   - AXI-Stream output
//             dp_stall, dp_aresetn, dp_inp_frame,
//             dp_out_frame                           - datapath interface
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_stream_ctrl #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
  parameter int LATENCY         = 24
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_sync,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic                  dp_stall,
  output logic                  dp_aresetn,
  output logic [DATA_WIDTH-1:0] dp_inp_frame,
  input  logic [DATA_WIDTH-1:0] dp_out_frame
);

  localparam int COLS    = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W   = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;
  localparam int FLUSH_W = $clog2(LATENCY + 1);

  localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(IMAGE_DIM - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                 err_sync_q, err_sync_d;

  // Tag pipeline: entry i describes the beat sitting in datapath stage i.
  logic [LATENCY-1:0]   tag_valid_q, tag_valid_d;
  logic [LATENCY-1:0]   tag_last_q, tag_last_d;
  logic [LATENCY-1:0]   tag_user_q, tag_user_d;

  // 2-entry output FIFO.
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic [1:0]            fifo_user_q, fifo_user_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            fifo_count_q, fifo_count_d;

  logic pop;
  logic push;
  logic room;
  logic blk;
  logic adv;
  logic accept;
  logic last_col;
  logic first_beat;

  // A beat leaving the last datapath stage needs a FIFO slot; a pop in the
  // same cycle frees one, so the slot check accounts for it.
  assign pop        = (fifo_count_q != 2'd0) & m_tready;
  assign room       = (fifo_count_q - {1'b0, pop}) < 2'd2;
  assign blk        = tag_valid_q[LATENCY-1] & ~room;
  assign accept     = (state_q == S_RUN) & adv;
  assign push       = adv & tag_valid_q[LATENCY-1];
  assign last_col   = (col_q == LAST_COL);
  assign first_beat = (col_q == '0) & (row_q == '0);

  always_comb begin
    adv = 1'b0;
    case (state_q)
      S_RUN:   adv = s_tvalid & ~blk;
      S_FLUSH: adv = ~blk;
      default: adv = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM, counters, framing check and tag pipeline
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    flush_cnt_d = flush_cnt_q;
    err_sync_d  = err_sync_q;
    tag_valid_d = tag_valid_q;
    tag_last_d  = tag_last_q;
    tag_user_d  = tag_user_q;

    if (adv) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        tag_valid_d[i] = tag_valid_q[i-1];
        tag_last_d[i]  = tag_last_q[i-1];
        tag_user_d[i]  = tag_user_q[i-1];
      end
      // During FLUSH accept is 0, so zero beats enter with an invalid tag.
      tag_valid_d[0] = accept;
      tag_last_d[0]  = last_col;
      tag_user_d[0]  = first_beat;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLR;
          err_sync_d = 1'b0;
        end
      end
      S_CLR: begin
        state_d     = S_RUN;
        col_d       = '0;
        row_d       = '0;
        flush_cnt_d = '0;
        err_sync_d  = 1'b0;
        tag_valid_d = '0;
        tag_last_d  = '0;
        tag_user_d  = '0;
      end
      S_RUN: begin
        if (accept) begin
          // Input framing is only checked; output framing follows counters.
          if ((s_tlast != last_col) || (s_tuser != first_beat)) begin
            err_sync_d = 1'b1;
          end
          if (last_col) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (adv) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_q == FLUSH_END) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_count_q == 2'd0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  always_comb begin
    fifo_data_d  = fifo_data_q;
    fifo_last_d  = fifo_last_q;
    fifo_user_d  = fifo_user_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;

    if (push) begin
      fifo_data_d[wr_ptr_q] = dp_out_frame;
      fifo_last_d[wr_ptr_q] = tag_last_q[LATENCY-1];
      fifo_user_d[wr_ptr_q] = tag_user_q[LATENCY-1];
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + 2'd1;
      2'b01:   fifo_count_d = fifo_count_q - 2'd1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      flush_cnt_q  <= '0;
      err_sync_q   <= 1'b0;
      tag_valid_q  <= '0;
      tag_last_q   <= '0;
      tag_user_q   <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q  <= '0;
      fifo_user_q  <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_count_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      flush_cnt_q  <= flush_cnt_d;
      err_sync_q   <= err_sync_d;
      tag_valid_q  <= tag_valid_d;
      tag_last_q   <= tag_last_d;
      tag_user_q   <= tag_user_d;
      fifo_data_q[0] <= fifo_data_d[0];
      fifo_data_q[1] <= fifo_data_d[1];
      fifo_last_q  <= fifo_last_d;
      fifo_user_q  <= fifo_user_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_DRAIN) & (fifo_count_q == 2'd0);
  assign err_sync     = err_sync_q;
  assign s_tready     = (state_q == S_RUN) & ~blk;
  assign dp_stall     = ~adv;
  assign dp_aresetn   = aresetn & (state_q != S_CLR);
  assign dp_inp_frame = (state_q == S_RUN) ? s_tdata : '0;

  // Head outputs are gated so idle outputs read as zero.
  assign m_tvalid = (fifo_count_q != 2'd0);
  assign m_tdata  = m_tvalid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_tlast  = m_tvalid & fifo_last_q[rd_ptr_q];
  assign m_tuser  = m_tvalid & fifo_user_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_stream_ctrl
//  Purpose  : Directed self-checking bench for sobel_stream_ctrl with a
//             5-stage stall-able delay line standing in for the datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_stream_ctrl;

  localparam int PPB    = 4;
  localparam int DIM    = 16;
  localparam int DW     = 8 * PPB;
  localparam int LAT    = 5;
  localparam int NBEATS = 64;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          busy, frame_done, err_sync;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast, m_tuser;
  logic          dp_stall, dp_aresetn;
  logic [DW-1:0] dp_inp_frame, dp_out_frame;

  always #5 clk = ~clk;

  sobel_stream_ctrl #(
    .PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .DATA_WIDTH(DW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .aresetn(aresetn), .start(start), .busy(busy),
    .frame_done(frame_done), .err_sync(err_sync),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .dp_stall(dp_stall), .dp_aresetn(dp_aresetn),
    .dp_inp_frame(dp_inp_frame), .dp_out_frame(dp_out_frame)
  );

  // Behavioural datapath: stall-able delay line.
  logic [DW-1:0] dp_pipe [LAT];
  always @(posedge clk) begin
    if (!dp_aresetn) begin
      for (int i = 0; i < LAT; i++) dp_pipe[i] <= '0;
    end else if (!dp_stall) begin
      for (int i = LAT - 1; i > 0; i--) dp_pipe[i] <= dp_pipe[i-1];
      dp_pipe[0] <= dp_inp_frame;
    end
  end
  assign dp_out_frame = dp_pipe[LAT-1];

  int total = 0;
  int bad   = 0;

  // Results of the most recent run_frame call.
  logic [DW-1:0] out_data [128];
  logic          out_last [128];
  logic          out_user [128];
  int out_n, done_cyc, last_pop, done_pulses, err_first, acc2;
  int stall_viol, model_viol, stab_viol, vlow_viol, maxcnt, rst_low;
  bit timeout, busy_after, err_end, err_c1, post_valid;

  // Drives one frame and records what comes out. tr_mode toggles m_tready
  // 1,0,0,1; v_mode randomises s_tvalid; abort_at stops after that many
  // accepted beats; extra_start_at pulses start again mid-frame.
  task automatic run_frame(input bit tr_mode, input bit v_mode, input bit bad_last,
                           input int abort_at, input int extra_start_at);
    int in_idx, cnt;
    logic [LAT-1:0] tv;
    bit hold, done_seen, extra_done, pop, push, acc;
    logic [DW-1:0] hd;
    logic hl, hu;
    out_n = 0; done_cyc = -1; last_pop = -1; done_pulses = 0; err_first = -1; acc2 = -1;
    stall_viol = 0; model_viol = 0; stab_viol = 0; vlow_viol = 0; maxcnt = 0; rst_low = 0;
    timeout = 1'b0; busy_after = 1'b1; err_end = 1'b0; err_c1 = 1'b1; post_valid = 1'b1;
    in_idx = 0; cnt = 0; tv = '0; hold = 1'b0; done_seen = 1'b0; extra_done = 1'b0;
    hd = '0; hl = 1'b0; hu = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (done_seen) begin
        start = 1'b0; s_tvalid = 1'b0;
        @(negedge clk);
        busy_after = busy; err_end = err_sync; post_valid = m_tvalid;
        break;
      end
      start = (cyc == 0);
      if (extra_start_at >= 0 && in_idx >= extra_start_at && !extra_done) begin
        start = 1'b1; extra_done = 1'b1;
      end
      s_tvalid = (in_idx < NBEATS) ? (v_mode ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      s_tdata  = DW'(in_idx);
      s_tlast  = bad_last ? ((in_idx == 2) || (in_idx % 4 == 3 && in_idx != 3)) : (in_idx % 4 == 3);
      s_tuser  = (in_idx == 0);
      m_tready = tr_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      @(negedge clk);
      pop  = m_tvalid && m_tready;
      push = !dp_stall && tv[LAT-1];
      acc  = s_tvalid && s_tready;
      if (m_tvalid !== (cnt != 0)) model_viol++;
      if (tv[LAT-1] && (cnt - int'(pop)) >= 2 && !dp_stall) stall_viol++;
      if (!s_tvalid && in_idx < NBEATS && !dp_stall) vlow_viol++;
      if (!dp_aresetn) rst_low++;
      if (cyc == 1) err_c1 = err_sync;
      if (err_sync && err_first < 0) err_first = cyc;
      if (hold && (!m_tvalid || m_tdata !== hd || m_tlast !== hl || m_tuser !== hu)) stab_viol++;
      hold = m_tvalid && !m_tready; hd = m_tdata; hl = m_tlast; hu = m_tuser;
      if (pop) begin
        if (out_n < 128) begin
          out_data[out_n] = m_tdata; out_last[out_n] = m_tlast; out_user[out_n] = m_tuser;
        end
        out_n++; last_pop = cyc;
      end
      if (frame_done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
        done_seen = 1'b1;
      end
      if (acc) begin
        if (in_idx == 2) acc2 = cyc;
        in_idx++;
      end
      if (!dp_aresetn) tv = '0;
      else if (!dp_stall) tv = {tv[LAT-2:0], acc};
      cnt = cnt + int'(push) - int'(pop);
      if (cnt > maxcnt) maxcnt = cnt;
      if (abort_at >= 0 && in_idx >= abort_at) break;
    end
    start = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
    if (!done_seen && abort_at < 0) timeout = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", frame_done); end
    total++; if (err_sync !== 1'b0)   begin bad++; $display("FAIL rst_err got %b want 0", err_sync); end
    total++; if (s_tready !== 1'b0)   begin bad++; $display("FAIL rst_tready got %b want 0", s_tready); end
    total++; if (m_tvalid !== 1'b0)   begin bad++; $display("FAIL rst_mvalid got %b want 0", m_tvalid); end
    total++; if ({m_tlast, m_tuser} !== 2'b00) begin bad++; $display("FAIL rst_mflags got %b want 00", {m_tlast, m_tuser}); end
    total++; if (m_tdata !== '0)      begin bad++; $display("FAIL rst_mdata got %h want 0", m_tdata); end
    total++; if (dp_stall !== 1'b1)   begin bad++; $display("FAIL rst_stall got %b want 1", dp_stall); end
    total++; if (dp_aresetn !== 1'b0) begin bad++; $display("FAIL rst_dprst got %b want 0", dp_aresetn); end
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic;
    int nbad;
    run_frame(1'b0, 1'b0, 1'b0, -1, -1);
    nbad = 0;
    for (int i = 0; i < NBEATS; i++)
      if (out_data[i] !== DW'(i) || out_last[i] !== (i % 4 == 3) || out_user[i] !== (i == 0)) nbad++;
    total++; if (timeout)          begin bad++; $display("FAIL basic_timeout got 1 want 0"); end
    total++; if (out_n !== NBEATS) begin bad++; $display("FAIL basic_count got %0d want %0d", out_n, NBEATS); end
    total++; if (nbad !== 0)       begin bad++; $display("FAIL basic_beats got %0d wrong want 0", nbad); end
    total++; if (done_cyc !== last_pop + 1) begin bad++; $display("FAIL basic_done_cyc got %0d want %0d", done_cyc, last_pop + 1); end
    total++; if (done_pulses !== 1) begin bad++; $display("FAIL basic_done_pulses got %0d want 1", done_pulses); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_after got %b want 0", busy_after); end
    total++; if (model_viol !== 0) begin bad++; $display("FAIL basic_mvalid got %0d bad cycles want 0", model_viol); end
    total++; if (rst_low !== 1)    begin bad++; $display("FAIL basic_dprst_len got %0d want 1", rst_low); end
  endtask

  task automatic test_backpressure;
    int nbad;
    run_frame(1'b1, 1'b0, 1'b0, -1, -1);
    nbad = 0;
    for (int i = 0; i < NBEATS; i++)
      if (out_data[i] !== DW'(i) || out_last[i] !== (i % 4 == 3) || out_user[i] !== (i == 0)) nbad++;
    total++; if (out_n !== NBEATS) begin bad++; $display("FAIL bp_count got %0d want %0d", out_n, NBEATS); end
    total++; if (nbad !== 0)       begin bad++; $display("FAIL bp_beats got %0d wrong want 0", nbad); end
    total++; if (stab_viol !== 0)  begin bad++; $display("FAIL bp_stable got %0d changes want 0", stab_viol); end
    total++; if (maxcnt > 2)       begin bad++; $display("FAIL bp_fifo_max got %0d want <=2", maxcnt); end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL bp_stall got %0d missing stalls want 0", stall_viol); end
    total++; if (model_viol !== 0) begin bad++; $display("FAIL bp_mvalid got %0d bad cycles want 0", model_viol); end
    total++; if (done_cyc !== last_pop + 1) begin bad++; $display("FAIL bp_done_cyc got %0d want %0d", done_cyc, last_pop + 1); end
  endtask

  task automatic test_valid_gaps;
    int nbad;
    run_frame(1'b0, 1'b1, 1'b0, -1, -1);
    nbad = 0;
    for (int i = 0; i < NBEATS; i++)
      if (out_data[i] !== DW'(i) || out_last[i] !== (i % 4 == 3) || out_user[i] !== (i == 0)) nbad++;
    total++; if (out_n !== NBEATS) begin bad++; $display("FAIL gaps_count got %0d want %0d", out_n, NBEATS); end
    total++; if (nbad !== 0)       begin bad++; $display("FAIL gaps_beats got %0d wrong want 0", nbad); end
    total++; if (vlow_viol !== 0)  begin bad++; $display("FAIL gaps_adv got %0d advances without valid want 0", vlow_viol); end
  endtask

  task automatic test_framing_err;
    int nbad;
    run_frame(1'b0, 1'b0, 1'b1, -1, -1);
    nbad = 0;
    for (int i = 0; i < NBEATS; i++)
      if (out_data[i] !== DW'(i) || out_last[i] !== (i % 4 == 3) || out_user[i] !== (i == 0)) nbad++;
    total++; if (err_first !== acc2 + 1) begin bad++; $display("FAIL err_rise got cycle %0d want %0d", err_first, acc2 + 1); end
    total++; if (out_n !== NBEATS) begin bad++; $display("FAIL err_count got %0d want %0d", out_n, NBEATS); end
    total++; if (nbad !== 0)       begin bad++; $display("FAIL err_beats got %0d wrong want 0", nbad); end
    total++; if (err_end !== 1'b1) begin bad++; $display("FAIL err_sticky got %b want 1", err_end); end
    run_frame(1'b0, 1'b0, 1'b0, -1, -1);
    total++; if (err_c1 !== 1'b0)  begin bad++; $display("FAIL err_clear_start got %b want 0", err_c1); end
    total++; if (err_end !== 1'b0) begin bad++; $display("FAIL err_clean_end got %b want 0", err_end); end
  endtask

  task automatic test_reset_mid;
    int nbad, act;
    run_frame(1'b0, 1'b0, 1'b0, 20, -1);
    @(posedge clk); #1 aresetn = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    total++; if (dp_aresetn !== 1'b0) begin bad++; $display("FAIL mid_dprst got %b want 0", dp_aresetn); end
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_mvalid got %b want 0", m_tvalid); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy got %b want 0", busy); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL mid_tready got %b want 0", s_tready); end
    total++; if (dp_stall !== 1'b1) begin bad++; $display("FAIL mid_stall got %b want 1", dp_stall); end
    act = 0;
    repeat (30) begin
      @(negedge clk);
      if (m_tvalid || busy) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL mid_quiet got %0d active cycles want 0", act); end
    run_frame(1'b0, 1'b0, 1'b0, -1, -1);
    nbad = 0;
    for (int i = 0; i < NBEATS; i++)
      if (out_data[i] !== DW'(i) || out_last[i] !== (i % 4 == 3) || out_user[i] !== (i == 0)) nbad++;
    total++; if (out_n !== NBEATS) begin bad++; $display("FAIL mid_count got %0d want %0d", out_n, NBEATS); end
    total++; if (nbad !== 0)       begin bad++; $display("FAIL mid_beats got %0d wrong want 0", nbad); end
  endtask

  task automatic test_start_busy;
    int nbad;
    run_frame(1'b0, 1'b0, 1'b0, -1, 10);
    nbad = 0;
    for (int i = 0; i < NBEATS; i++)
      if (out_data[i] !== DW'(i) || out_last[i] !== (i % 4 == 3) || out_user[i] !== (i == 0)) nbad++;
    total++; if (rst_low !== 1)    begin bad++; $display("FAIL busy_dprst_len got %0d want 1", rst_low); end
    total++; if (out_n !== NBEATS) begin bad++; $display("FAIL busy_count got %0d want %0d", out_n, NBEATS); end
    total++; if (nbad !== 0)       begin bad++; $display("FAIL busy_beats got %0d wrong want 0", nbad); end
    total++; if (done_pulses !== 1) begin bad++; $display("FAIL busy_done_pulses got %0d want 1", done_pulses); end
    total++; if (post_valid !== 1'b0) begin bad++; $display("FAIL busy_post_valid got %b want 0", post_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_valid_gaps();
    test_framing_err();
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_stream_ctrl.md
Name: sobel_stream_ctrl

Overview:
- Sequences one stall-able Sobel convolution datapath (PIXELS_PER_BEAT pixels per beat, IMAGE_DIM x IMAGE_DIM frame) between an AXI-Stream input and an AXI-Stream output.
- Generates the datapath stall and the per-frame datapath reset.
- Tracks which datapath pipeline stages hold valid beats, flushes the pipeline at end of frame, and buffers results in a 2-entry output FIFO so downstream backpressure never corrupts data.
- Regenerates row/frame framing (tlast/tuser) from internal counters.

Parameters:
- PIXELS_PER_BEAT, 16, pixels per beat (8 bit each).
- IMAGE_DIM, 512, frame width and height in pixels.
- DATA_WIDTH, 8*PIXELS_PER_BEAT, beat width.
- LATENCY, 24, datapath depth in enabled (non-stalled) cycles from dp_inp_frame to dp_out_frame.
- Derived: COLS = IMAGE_DIM/PIXELS_PER_BEAT, beats per row.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- start  in  1  pulse; begins a frame when idle, ignored otherwise.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the last output beat leaves the FIFO.
- err_sync  out  1  sticky framing-error flag; cleared by reset or start.
- s_tdata  in  DATA_WIDTH  input pixels.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- s_tlast  in  1  end of row, checked only.
- s_tuser  in  1  start of frame, checked only.
- m_tdata  out  DATA_WIDTH  gradient magnitudes.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tlast  out  1  end of row.
- m_tuser  out  1  first beat of frame.
- dp_stall  out  1  datapath freeze.
- dp_aresetn  out  1  datapath reset, active-low.
- dp_inp_frame  out  DATA_WIDTH  datapath input.
- dp_out_frame  in  DATA_WIDTH  datapath output.

Behaviour:
- Reset values:
  - state=IDLE, busy=0, frame_done=0, err_sync=0.
  - s_tready=0, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0.
  - dp_stall=1, dp_aresetn=0 (follows aresetn).
  - FIFO empty; all tags cleared; counters 0.
  - Reset mid-frame discards all in-flight data; there is no output after reset until the next start.
- States:
  - IDLE: start -> CLR.
  - CLR: exactly one cycle; dp_aresetn=0, dp_stall=1, err_sync cleared -> RUN.
  - RUN: accepts the frame. When the accepted beat has row=IMAGE_DIM-1 and col=COLS-1 -> FLUSH.
  - FLUSH: injects LATENCY zero beats (dp_inp_frame=0, valid tag=0). flush_cnt counts adv cycles; at LATENCY -> DRAIN.
  - DRAIN: waits for the FIFO to empty, then pulses frame_done -> IDLE.
- Advance: adv = ~dp_stall.
  - room = (fifo_count - pop) < 2, where pop = m_tvalid & m_tready.
  - blk = tag_valid[LATENCY-1] & ~room.
  - RUN: adv = s_tvalid & ~blk. FLUSH: adv = ~blk. All other states: adv = 0.
- Input handshake:
  - s_tready = (state==RUN) & ~blk.
  - Accept = s_tvalid & s_tready (identical to adv in RUN).
  - dp_inp_frame = s_tdata in RUN, 0 otherwise.
- Tag pipeline: LATENCY entries of {valid, last, user}, shifted only on adv.
  - Entry 0 loads {accept, col==COLS-1, col==0 & row==0}.
  - Entry LATENCY-1 aligns with dp_out_frame.
- FIFO write: on adv & tag_valid[LATENCY-1], write {dp_out_frame, last, user}, sampled before the edge.
  - Simultaneous push and pop are allowed; count is unchanged.
  - Never overflows (guaranteed by blk). A pop on empty cannot occur.
- Output: m_tvalid = FIFO non-empty; m_tdata, m_tlast and m_tuser come from the FIFO head.
  - All m_* signals are held stable while m_tvalid & ~m_tready.
- Counters:
  - col counts 0..COLS-1 on accept, wrapping to 0 with row+1.
  - row counts 0..IMAGE_DIM-1.
  - Both clear in CLR.
- Framing check on each accept: err_sync sets if s_tlast != (col==COLS-1) or s_tuser != (col==0 & row==0).
  - Processing continues; output framing always follows the internal counters.
- frame_done is asserted in the cycle after the final pop. Exactly IMAGE_DIM*COLS output beats are produced per frame.

Test Plan:
All scenarios use PIXELS_PER_BEAT=4, IMAGE_DIM=16 (COLS=4, 64 beats) and LATENCY=5, with a behavioural datapath modelled as a 5-stage stall-able delay line.
1. Reset then start, s_tvalid and m_tready held 1, data = beat index -> exactly 64 output beats with data 0..63 in order; m_tuser only on beat 0; m_tlast on beats 3,7,...,63; frame_done one cycle after beat 63 pops; busy low afterwards.
2. Same stream with m_tready toggling 1,0,0,1 -> identical data order; m_tdata stable while stalled; FIFO count never exceeds 2; dp_stall=1 whenever a valid last-stage tag has no FIFO room.
3. s_tvalid randomly low 50% of cycles -> same 64 outputs; tags never advance on cycles with s_tvalid=0 in RUN.
4. s_tlast asserted on beat 2 instead of beat 3 -> err_sync=1 from the cycle after beat 2 is accepted; outputs still 64 beats with m_tlast on beat 3; a second start clears err_sync.
5. aresetn low for one cycle after 20 input beats -> all outputs idle; m_tvalid=0; a fresh start produces a full, correct 64-beat frame.
6. start pulsed while busy -> ignored; dp_aresetn is low for exactly one cycle per accepted start.
